loop_arbiter: RTL

Time-shares one tracking-loop datapath among `NUM_CH` correlator channels. Each channel emits a one-cycle `i2q2_valid`-style strobe with its per-epoch history bundle. The arbiter captures the bundle, grants the loop to pending channels in round-robin order, and routes each loop result back to its owner as a one-cycle strobe. It sits in the top level between the channel instances and a single loop instance, replacing one loop per channel.

---
 rtl/loop_arbiter_pkg.sv | 63 ++++++
 rtl/loop_arbiter_rr_select.sv | 35 +++
 rtl/loop_arbiter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/loop_arbiter_pkg.sv
// loop_arbiter_pkg
//   Shared definitions for the loop arbiter: FSM state encoding and the
//   field layout of the channel-history and loop-result bundles, plus
//   pack helpers so the top level and the channel/loop instances agree
//   on where each field sits.
package loop_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  // Channel-history bundle (LSB offsets)
  localparam int REQ_E_LSB     = 0;    // early I2+Q2, 16b
  localparam int REQ_P_LSB     = 16;   // prompt I2+Q2, 16b
  localparam int REQ_L_LSB     = 32;   // late I2+Q2, 16b
  localparam int REQ_IQK_LSB   = 48;   // prompt IQ, epoch k, 16b
  localparam int REQ_IQKM1_LSB = 64;   // prompt IQ, epoch k-1, 16b
  localparam int REQ_WDF_LSB   = 80;   // w_df, 24b
  localparam int REQ_WDFD_LSB  = 104;  // w_df_dot, 24b
  localparam int REQ_BUNDLE_W  = 128;

  // Loop-result bundle (LSB offsets)
  localparam int RES_IQK_LSB   = 0;    // iq_prompt_k, 16b
  localparam int RES_DOP_LSB   = 16;   // doppler_inc_kp1, 24b
  localparam int RES_WDF_LSB   = 40;   // w_df_kp1, 24b
  localparam int RES_WDFD_LSB  = 64;   // w_df_dot_kp1, 16b
  localparam int RES_DPHI_LSB  = 80;   // ca_dphi_kp1, 16b
  localparam int RES_BUNDLE_W  = 96;

  function automatic logic [REQ_BUNDLE_W-1:0] pack_req(
    input logic [15:0] e, p, l, iqk, iqkm1,
    input logic [23:0] wdf, wdfd
  );
    logic [REQ_BUNDLE_W-1:0] b;
    b = '0;
    b[REQ_E_LSB     +: 16] = e;
    b[REQ_P_LSB     +: 16] = p;
    b[REQ_L_LSB     +: 16] = l;
    b[REQ_IQK_LSB   +: 16] = iqk;
    b[REQ_IQKM1_LSB +: 16] = iqkm1;
    b[REQ_WDF_LSB   +: 24] = wdf;
    b[REQ_WDFD_LSB  +: 24] = wdfd;
    return b;
  endfunction

  function automatic logic [RES_BUNDLE_W-1:0] pack_res(
    input logic [15:0] iqk,
    input logic [23:0] dop, wdf,
    input logic [15:0] wdfd, dphi
  );
    logic [RES_BUNDLE_W-1:0] b;
    b = '0;
    b[RES_IQK_LSB  +: 16] = iqk;
    b[RES_DOP_LSB  +: 24] = dop;
    b[RES_WDF_LSB  +: 24] = wdf;
    b[RES_WDFD_LSB +: 16] = wdfd;
    b[RES_DPHI_LSB +: 16] = dphi;
    return b;
  endfunction

endpackage

// File: rtl/loop_arbiter_rr_select.sv
// rr_select
//   Combinational round-robin priority encoder. Searches pending starting
//   at last_grant+1 (mod NUM_CH) and reports the first set bit.
//   pending    in   NUM_CH  request vector
//   last_grant in   IDX_W   most recently granted channel
//   found      out  1       any request present
//   grant_idx  out  IDX_W   winning channel (0 when none found)
module rr_select #(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = 2
) (
  input  logic [NUM_CH-1:0] pending,
  input  logic [IDX_W-1:0]  last_grant,
  output logic              found,
  output logic [IDX_W-1:0]  grant_idx
);

  logic [IDX_W-1:0] cand;

  // Walk from the farthest offset to the nearest so the closest pending
  // channel after last_grant overwrites any earlier hit.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int off = NUM_CH; off >= 1; off--) begin
      cand = IDX_W'((int'(last_grant) + off) % NUM_CH);
      if (pending[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
  end

endmodule

// File: rtl/loop_arbiter.sv
// loop_arbiter
//   Time-shares one tracking-loop datapath among NUM_CH correlator channels.
//   Captures per-channel history bundles, grants the loop round-robin and
//   returns each result to its owner as a one-cycle strobe.
//   clk         in   1             system clock
//   reset       in   1             synchronous, active-high
//   req_valid   in   NUM_CH        per-channel bundle strobe
//   req_data    in   NUM_CH*REQ_W  per-channel bundles, ch c at [c*REQ_W +: REQ_W]
//   loop_start  out  1             launches the loop
//   loop_data   out  REQ_W         bundle to the loop, stable through service
//   loop_ready  in   1             loop result valid
//   loop_result in   RES_W         loop result
//   res_valid   out  NUM_CH        one-hot result strobe to owner
//   res_data    out  RES_W         result bundle
//   busy        out  1             ISSUE or WAIT
//   overrun     out  NUM_CH        sticky, strobe while pending/in service
//   timeout     out  1             sticky, loop did not answer in time
//
// state | meaning
// IDLE  | no transaction; pick next pending channel
// ISSUE | loop_start pulse, winner's bundle copied to service register
// WAIT  | waiting for loop_ready or the timeout count
module loop_arbiter
  import loop_arbiter_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int REQ_W   = REQ_BUNDLE_W,
  parameter int RES_W   = RES_BUNDLE_W,
  parameter int TIMEOUT = 1023
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       req_valid,
  input  logic [NUM_CH*REQ_W-1:0] req_data,
  output logic                    loop_start,
  output logic [REQ_W-1:0]        loop_data,
  input  logic                    loop_ready,
  input  logic [RES_W-1:0]        loop_result,
  output logic [NUM_CH-1:0]       res_valid,
  output logic [RES_W-1:0]        res_data,
  output logic                    busy,
  output logic [NUM_CH-1:0]       overrun,
  output logic                    timeout
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e                        state_q, state_d;
  logic [NUM_CH-1:0][REQ_W-1:0]  hold_q;
  logic [NUM_CH-1:0]             pending_q, pending_d;
  logic [NUM_CH-1:0]             overrun_q, overrun_d;
  logic [NUM_CH-1:0]             res_valid_q, res_valid_d;
  logic [NUM_CH-1:0]             grant_oh, svc_oh;
  logic [REQ_W-1:0]              svc_q, svc_d;
  logic [RES_W-1:0]              res_data_q, res_data_d;
  logic [IDX_W-1:0]              last_grant_q, last_grant_d;
  logic [IDX_W-1:0]              winner_q, winner_d;
  logic [IDX_W-1:0]              sel_idx;
  logic                          sel_found;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic                          timeout_q, timeout_d;

  rr_select #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_rr_select (
    .pending    (pending_q),
    .last_grant (last_grant_q),
    .found      (sel_found),
    .grant_idx  (sel_idx)
  );

  always_comb begin
    state_d      = state_q;
    winner_d     = winner_q;
    last_grant_d = last_grant_q;
    svc_d        = svc_q;
    cnt_d        = cnt_q;
    res_data_d   = res_data_q;
    res_valid_d  = '0;
    timeout_d    = timeout_q;
    grant_oh     = '0;
    svc_oh       = '0;
    loop_start   = 1'b0;
    loop_data    = svc_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (sel_found) begin
          winner_d = sel_idx;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        loop_start         = 1'b1;
        loop_data          = hold_q[winner_q];
        svc_d              = hold_q[winner_q];
        grant_oh[winner_q] = 1'b1;
        svc_oh[winner_q]   = 1'b1;
        last_grant_d       = winner_q;
        cnt_d              = '0;
        state_d            = ST_WAIT;
      end
      ST_WAIT: begin
        svc_oh[winner_q] = 1'b1;
        if (loop_ready) begin
          res_data_d            = loop_result;
          res_valid_d[winner_q] = 1'b1;
          state_d               = ST_IDLE;
        end else if (cnt_q + CNT_W'(1) == CNT_W'(TIMEOUT)) begin
          // Loop has had TIMEOUT cycles in WAIT; give up on it.
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A new strobe wins over the ISSUE clear of the same channel.
    pending_d = (pending_q & ~grant_oh) | req_valid;
    overrun_d = overrun_q | (req_valid & (pending_q | svc_oh));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      hold_q       <= '0;
      pending_q    <= '0;
      overrun_q    <= '0;
      res_valid_q  <= '0;
      svc_q        <= '0;
      res_data_q   <= '0;
      last_grant_q <= IDX_W'(NUM_CH - 1);
      winner_q     <= '0;
      cnt_q        <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      overrun_q    <= overrun_d;
      res_valid_q  <= res_valid_d;
      svc_q        <= svc_d;
      res_data_q   <= res_data_d;
      last_grant_q <= last_grant_d;
      winner_q     <= winner_d;
      cnt_q        <= cnt_d;
      timeout_q    <= timeout_d;
      for (int c = 0; c < NUM_CH; c++) begin
        if (req_valid[c]) hold_q[c] <= req_data[c*REQ_W +: REQ_W];
      end
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign busy      = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign overrun   = overrun_q;
  assign timeout   = timeout_q;

endmodule
